// File: rtl/scie_fir_sequencer.sv
// scie_fir_sequencer: issues coefficient-load (0x0B), sample-push (0x2B) and
// result-read (0x5B) instructions to the pipelined complex FIR unit in the
// required order, and returns each filter result on a valid/ready stream.
// Optional build macro: SCIE_SEQ_COEF_CHECK_EN -- samples are held off until
// every tap has been written at least once since reset.
module scie_fir_sequencer #(
    parameter int unsigned NTAPS      = 5,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned RD_LAT     = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic [31:0]        coef_idx,
    input  logic signed [63:0] coef_real,
    input  logic signed [63:0] coef_imag,
    input  logic               smp_valid,
    output logic               smp_ready,
    input  logic signed [63:0] smp_real,
    input  logic signed [63:0] smp_imag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [63:0] res_real,
    output logic signed [63:0] res_imag,
    output logic               coef_err,
    output logic               busy,
    output logic               dp_valid,
    output logic [31:0]        dp_insn,
    output logic signed [63:0] dp_rs1_real,
    output logic signed [63:0] dp_rs1_imag,
    output logic [31:0]        dp_rs2,
    input  logic signed [63:0] dp_rd_real,
    input  logic signed [63:0] dp_rd_imag
);
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 32;
    localparam int unsigned CW = 16;

    localparam logic [IW-1:0] INSN_COEF = 32'h0000_000B;
    localparam logic [IW-1:0] INSN_PUSH = 32'h0000_002B;
    localparam logic [IW-1:0] INSN_READ = 32'h0000_005B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COEF,
        S_PUSH,
        S_GAP,
        S_READ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_dp_valid;
    logic [IW-1:0]         r_dp_insn;
    logic signed [DW-1:0]  r_rs1_real;
    logic signed [DW-1:0]  r_rs1_imag;
    logic [IW-1:0]         r_rs2;
    logic                  r_res_valid;
    logic signed [DW-1:0]  r_res_real;
    logic signed [DW-1:0]  r_res_imag;
    logic                  r_coef_err;

    logic                  w_idle;
    logic                  w_taps_ok;
    logic                  w_coef_in_range;
    logic                  w_coef_fire;
    logic                  w_smp_fire;

    assign w_idle          = (r_state == S_IDLE);
    assign w_coef_in_range = (coef_idx < IW'(NTAPS));
    assign w_coef_fire     = coef_valid & w_idle;
    // Ready is a pure state decode; a sample seen alongside a coefficient is
    // not taken that cycle, so the producer keeps it presented.
    assign w_smp_fire      = smp_valid & smp_ready & ~coef_valid;

`ifdef SCIE_SEQ_COEF_CHECK_EN
    logic [NTAPS-1:0] r_tap_seen;

    // Record which in-range taps have been written since reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tap_seen <= '0;
        end else if (w_coef_fire && w_coef_in_range) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                if (coef_idx == IW'(k)) begin
                    r_tap_seen[k] <= 1'b1;
                end
            end
        end
    end

    assign w_taps_ok = &r_tap_seen;
`else
    assign w_taps_ok = 1'b1;
`endif

    // Sequencer state, instruction issue and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dp_valid  <= 1'b0;
            r_dp_insn   <= '0;
            r_rs1_real  <= '0;
            r_rs1_imag  <= '0;
            r_rs2       <= '0;
            r_res_valid <= 1'b0;
            r_res_real  <= '0;
            r_res_imag  <= '0;
            r_coef_err  <= 1'b0;
        end else begin
            r_dp_valid <= 1'b0;
            r_coef_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_coef_fire) begin
                        if (w_coef_in_range) begin
                            r_state    <= S_COEF;
                            r_dp_valid <= 1'b1;
                            r_dp_insn  <= INSN_COEF;
                            r_rs1_real <= coef_real;
                            r_rs1_imag <= coef_imag;
                            r_rs2      <= coef_idx;
                        end else begin
                            r_coef_err <= 1'b1;
                        end
                    end else if (w_smp_fire) begin
                        r_state    <= S_PUSH;
                        r_dp_valid <= 1'b1;
                        r_dp_insn  <= INSN_PUSH;
                        r_rs1_real <= smp_real;
                        r_rs1_imag <= smp_imag;
                    end
                end
                S_COEF: begin
                    r_state <= S_IDLE;
                end
                S_PUSH: begin
                    if (GAP_CYCLES == 0) begin
                        r_state    <= S_READ;
                        r_dp_valid <= 1'b1;
                        r_dp_insn  <= INSN_READ;
                    end else begin
                        r_state <= S_GAP;
                        r_cnt   <= CW'(GAP_CYCLES - 1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state    <= S_READ;
                        r_dp_valid <= 1'b1;
                        r_dp_insn  <= INSN_READ;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_READ: begin
                    if (RD_LAT == 0) begin
                        r_state     <= S_HOLD;
                        r_res_valid <= 1'b1;
                        r_res_real  <= dp_rd_real;
                        r_res_imag  <= dp_rd_imag;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= CW'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_HOLD;
                        r_res_valid <= 1'b1;
                        r_res_real  <= dp_rd_real;
                        r_res_imag  <= dp_rd_imag;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign coef_ready  = w_idle;
    assign smp_ready   = w_idle & w_taps_ok;
    assign busy        = ~w_idle;
    assign coef_err    = r_coef_err;
    assign dp_valid    = r_dp_valid;
    assign dp_insn     = r_dp_insn;
    assign dp_rs1_real = r_rs1_real;
    assign dp_rs1_imag = r_rs1_imag;
    assign dp_rs2      = r_rs2;
    assign res_valid   = r_res_valid;
    assign res_real    = r_res_real;
    assign res_imag    = r_res_imag;

endmodule

// File: tb/tb_scie_fir_sequencer.sv
// Testbench for scie_fir_sequencer: a behavioural complex-FIR unit answers the
// issued instructions, and a reference convolution over the stimulus checks
// every returned result. Honours SCIE_SEQ_COEF_CHECK_EN when defined.
module tb_scie_fir_sequencer;
    localparam int NTAPS      = 5;
    localparam int GAP_CYCLES = 1;
    localparam int RD_LAT     = 0;
    localparam int SMP_PERIOD = 4 + GAP_CYCLES + RD_LAT;
    localparam int TIMEOUT    = 50;
    localparam logic [31:0] OP_COEF = 32'h0000_000B;
    localparam logic [31:0] OP_PUSH = 32'h0000_002B;
    localparam logic [31:0] OP_READ = 32'h0000_005B;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               coef_valid, coef_ready;
    logic [31:0]        coef_idx;
    logic signed [63:0] coef_real, coef_imag;
    logic               smp_valid, smp_ready;
    logic signed [63:0] smp_real, smp_imag;
    logic               res_valid, res_ready;
    logic signed [63:0] res_real, res_imag;
    logic               coef_err, busy, dp_valid;
    logic [31:0]        dp_insn, dp_rs2;
    logic signed [63:0] dp_rs1_real, dp_rs1_imag;
    logic signed [63:0] dp_rd_real = '0;
    logic signed [63:0] dp_rd_imag = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    scie_fir_sequencer #(.NTAPS(NTAPS), .GAP_CYCLES(GAP_CYCLES), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_idx(coef_idx),
        .coef_real(coef_real), .coef_imag(coef_imag),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_real(smp_real), .smp_imag(smp_imag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_real(res_real), .res_imag(res_imag),
        .coef_err(coef_err), .busy(busy),
        .dp_valid(dp_valid), .dp_insn(dp_insn),
        .dp_rs1_real(dp_rs1_real), .dp_rs1_imag(dp_rs1_imag), .dp_rs2(dp_rs2),
        .dp_rd_real(dp_rd_real), .dp_rd_imag(dp_rd_imag)
    );

    // Complex multiply-accumulate with 64-bit wraparound
    function automatic void cmac(input logic signed [63:0] ar, ai, br, bi,
                                 inout logic signed [63:0] accr, acci);
        accr = accr + ar * br - ai * bi;
        acci = acci + ar * bi + ai * br;
    endfunction

    function automatic logic signed [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Behavioural FIR unit: reacts to issued instructions, junk on rd otherwise
    logic signed [63:0] u_cr [NTAPS] = '{default: '0};
    logic signed [63:0] u_ci [NTAPS] = '{default: '0};
    logic signed [63:0] u_xr [NTAPS] = '{default: '0};
    logic signed [63:0] u_xi [NTAPS] = '{default: '0};
    int u_hold = 0;

    always @(negedge clock) begin
        logic signed [63:0] yr, yi;
        if (dp_valid === 1'b1 && dp_insn == OP_COEF) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (dp_rs2 == 32'(k)) begin
                    u_cr[k] = dp_rs1_real;
                    u_ci[k] = dp_rs1_imag;
                end
            end
        end
        if (dp_valid === 1'b1 && dp_insn == OP_PUSH) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                u_xr[k] = u_xr[k-1];
                u_xi[k] = u_xi[k-1];
            end
            u_xr[0] = dp_rs1_real;
            u_xi[0] = dp_rs1_imag;
        end
        if (dp_valid === 1'b1 && dp_insn == OP_READ) begin
            yr = '0;
            yi = '0;
            for (int k = 0; k < NTAPS; k++) cmac(u_cr[k], u_ci[k], u_xr[k], u_xi[k], yr, yi);
            dp_rd_real = yr;
            dp_rd_imag = yi;
            u_hold     = RD_LAT;
        end else if (u_hold > 0) begin
            u_hold--;
        end else begin
            dp_rd_real = rnd64();
            dp_rd_imag = rnd64();
        end
    end

    // Reference: coefficient table by tap, newest-first list of accepted samples
    logic signed [63:0] ref_cr [NTAPS] = '{default: '0};
    logic signed [63:0] ref_ci [NTAPS] = '{default: '0};
    logic signed [63:0] ref_xr [$];
    logic signed [63:0] ref_xi [$];
    bit ref_seen [NTAPS] = '{default: 1'b0};

    function automatic void ref_expect(output logic signed [63:0] er, ei);
        er = '0;
        ei = '0;
        for (int k = 0; k < NTAPS && k < ref_xr.size(); k++)
            cmac(ref_cr[k], ref_ci[k], ref_xr[k], ref_xi[k], er, ei);
    endfunction

    function automatic logic exp_smp_ready_idle();
`ifdef SCIE_SEQ_COEF_CHECK_EN
        for (int k = 0; k < NTAPS; k++) if (!ref_seen[k]) return 1'b0;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; coef_valid = 1'b0; smp_valid = 1'b0; res_ready = 1'b0;
        coef_idx = '0; coef_real = '0; coef_imag = '0; smp_real = '0; smp_imag = '0;
        for (int k = 0; k < NTAPS; k++) ref_seen[k] = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({dp_valid, res_valid, coef_err, busy} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 0000", {dp_valid, res_valid, coef_err, busy});
        end
        n_checks++;
        if (dp_insn !== 32'h0 || dp_rs2 !== 32'h0) begin
            n_errors++; $display("FAIL reset_insn_rs2: got %h/%h expected 0/0", dp_insn, dp_rs2);
        end
        n_checks++;
        if (dp_rs1_real !== 64'sd0 || dp_rs1_imag !== 64'sd0) begin
            n_errors++; $display("FAIL reset_rs1: got %0d/%0d expected 0/0", dp_rs1_real, dp_rs1_imag);
        end
        n_checks++;
        if (res_real !== 64'sd0 || res_imag !== 64'sd0) begin
            n_errors++; $display("FAIL reset_res: got %0d/%0d expected 0/0", res_real, res_imag);
        end
        n_checks++;
        if (coef_ready !== 1'b1 || smp_ready !== exp_smp_ready_idle()) begin
            n_errors++; $display("FAIL reset_ready: got coef %b smp %b expected 1 %b", coef_ready, smp_ready, exp_smp_ready_idle());
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || dp_valid !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_idle: got busy %b dp_valid %b expected 0 0", busy, dp_valid);
        end
    endtask

    // Drive one coefficient from a negedge in IDLE; returns at a negedge in IDLE
    task automatic load_coef(input logic [31:0] idx, input logic signed [63:0] cr, ci);
        n_checks++;
        if (coef_ready !== 1'b1 || smp_ready !== exp_smp_ready_idle()) begin
            n_errors++; $display("FAIL coef_pre_ready: got coef %b smp %b expected 1 %b", coef_ready, smp_ready, exp_smp_ready_idle());
        end
        coef_valid = 1'b1; coef_idx = idx; coef_real = cr; coef_imag = ci;
        @(negedge clock);
        coef_valid = 1'b0;
        if (idx < NTAPS) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (idx == 32'(k)) begin
                    ref_cr[k] = cr; ref_ci[k] = ci; ref_seen[k] = 1'b1;
                end
            end
            n_checks++;
            if (dp_valid !== 1'b1 || dp_insn !== OP_COEF || dp_rs2 !== idx || coef_err !== 1'b0) begin
                n_errors++; $display("FAIL coef_issue: got v %b insn %h rs2 %0d err %b expected 1 0b %0d 0", dp_valid, dp_insn, dp_rs2, coef_err, idx);
            end
            n_checks++;
            if (dp_rs1_real !== cr || dp_rs1_imag !== ci) begin
                n_errors++; $display("FAIL coef_rs1: got %0d/%0d expected %0d/%0d", dp_rs1_real, dp_rs1_imag, cr, ci);
            end
            n_checks++;
            if (coef_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++; $display("FAIL coef_busy: got ready %b busy %b expected 0 1", coef_ready, busy);
            end
            @(negedge clock);
            n_checks++;
            if (dp_valid !== 1'b0 || coef_ready !== 1'b1 || smp_ready !== exp_smp_ready_idle()) begin
                n_errors++; $display("FAIL coef_done: got v %b coef_rdy %b smp_rdy %b expected 0 1 %b", dp_valid, coef_ready, smp_ready, exp_smp_ready_idle());
            end
        end else begin
            n_checks++;
            if (coef_err !== 1'b1 || dp_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL coef_oob: got err %b v %b busy %b expected 1 0 0", coef_err, dp_valid, busy);
            end
            @(negedge clock);
            n_checks++;
            if (coef_err !== 1'b0 || dp_valid !== 1'b0) begin
                n_errors++; $display("FAIL coef_err_pulse: got err %b v %b expected 0 0", coef_err, dp_valid);
            end
        end
    endtask

    task automatic test_coef_load();
        load_coef(32'd0, 64'sd18467439133, -64'sd9303473443);
        for (int k = 1; k < NTAPS - 1; k++) load_coef(32'(k), rnd64(), rnd64());
        load_coef(32'(NTAPS - 1), 64'sd86606597970, 64'sd140317386008);
        load_coef(32'd7, rnd64(), rnd64());
        load_coef(32'(NTAPS) + $urandom_range(0, 100000), rnd64(), rnd64());
    endtask

    // One sample through PUSH/GAP/READ/HOLD with a chosen backpressure stall
    task automatic send_sample(input logic signed [63:0] xr, xi, input int stall);
        logic signed [63:0] er, ei;
        int waited = 0;
        smp_valid = 1'b1; smp_real = xr; smp_imag = xi; res_ready = 1'b0;
        while (smp_ready !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (smp_ready !== 1'b1) begin
            n_errors++; $display("FAIL smp_accept_timeout: got smp_ready %b expected 1", smp_ready);
            smp_valid = 1'b0;
            return;
        end
        ref_xr.push_front(xr); ref_xi.push_front(xi);
        ref_expect(er, ei);
        @(negedge clock);
        smp_valid = 1'b0;
        n_checks++;
        if (dp_valid !== 1'b1 || dp_insn !== OP_PUSH || dp_rs1_real !== xr || dp_rs1_imag !== xi || smp_ready !== 1'b0) begin
            n_errors++; $display("FAIL push_issue: got v %b insn %h rs1 %0d/%0d rdy %b expected 1 2b %0d/%0d 0", dp_valid, dp_insn, dp_rs1_real, dp_rs1_imag, smp_ready, xr, xi);
        end
        for (int g = 0; g < GAP_CYCLES; g++) begin
            @(negedge clock);
            n_checks++;
            if (dp_valid !== 1'b0 || busy !== 1'b1) begin
                n_errors++; $display("FAIL gap_idle: got v %b busy %b expected 0 1", dp_valid, busy);
            end
        end
        @(negedge clock);
        n_checks++;
        if (dp_valid !== 1'b1 || dp_insn !== OP_READ || res_valid !== 1'b0) begin
            n_errors++; $display("FAIL read_issue: got v %b insn %h res_valid %b expected 1 5b 0", dp_valid, dp_insn, res_valid);
        end
        for (int w = 0; w < RD_LAT; w++) @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (res_valid !== 1'b1 || res_real !== er || res_imag !== ei) begin
            n_errors++; $display("FAIL result: got v %b %0d/%0d expected 1 %0d/%0d", res_valid, res_real, res_imag, er, ei);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            n_checks++;
            if (res_valid !== 1'b1 || res_real !== er || res_imag !== ei || smp_ready !== 1'b0 || dp_valid !== 1'b0) begin
                n_errors++; $display("FAIL hold_stall: got v %b %0d/%0d rdy %b dpv %b expected 1 %0d/%0d 0 0", res_valid, res_real, res_imag, smp_ready, dp_valid, er, ei);
            end
        end
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL release_idle: got res_valid %b busy %b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_end_to_end();
        send_sample(64'sd214482138589, -64'sd36323334022, 0);
        send_sample(-64'sd126822616502, -64'sd169139455967, 10);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) load_coef(32'($urandom_range(0, NTAPS - 1)), rnd64(), rnd64());
            send_sample(rnd64(), rnd64(), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        logic signed [63:0] exp_r [$];
        logic signed [63:0] exp_i [$];
        logic signed [63:0] er, ei;
        int acc_cnt = 0, res_cnt = 0, last_acc = -1;
        bit pend = 1'b0;
        res_ready = 1'b1; smp_valid = 1'b1; smp_real = rnd64(); smp_imag = rnd64();
        for (int cyc = 0; cyc < 8 * SMP_PERIOD + 20 && res_cnt < 6; cyc++) begin
            if (res_valid === 1'b1) begin
                n_checks++;
                if (exp_r.size() == 0) begin
                    n_errors++; $display("FAIL b2b_extra_result: got %0d/%0d expected none", res_real, res_imag);
                end else begin
                    er = exp_r.pop_front(); ei = exp_i.pop_front();
                    if (res_real !== er || res_imag !== ei) begin
                        n_errors++; $display("FAIL b2b_result: got %0d/%0d expected %0d/%0d", res_real, res_imag, er, ei);
                    end
                end
                res_cnt++;
            end
            if (pend) begin
                pend = 1'b0;
                if (acc_cnt == 6) smp_valid = 1'b0;
                else begin smp_real = rnd64(); smp_imag = rnd64(); end
            end
            if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != SMP_PERIOD) begin
                        n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_acc, SMP_PERIOD);
                    end
                end
                last_acc = cyc;
                acc_cnt++;
                ref_xr.push_front(smp_real); ref_xi.push_front(smp_imag);
                ref_expect(er, ei);
                exp_r.push_back(er); exp_i.push_back(ei);
                pend = 1'b1;
            end
            @(negedge clock);
        end
        smp_valid = 1'b0; res_ready = 1'b0;
        n_checks++;
        if (res_cnt != 6 || acc_cnt != 6) begin
            n_errors++; $display("FAIL b2b_count: got %0d results %0d accepts expected 6 6", res_cnt, acc_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] idx;
        logic signed [63:0] cr, ci, xr, xi, er, ei;
        int waited = 0;
        idx = 32'($urandom_range(0, NTAPS - 1));
        cr = rnd64(); ci = rnd64(); xr = rnd64(); xi = rnd64();
        coef_valid = 1'b1; coef_idx = idx; coef_real = cr; coef_imag = ci;
        smp_valid = 1'b1; smp_real = xr; smp_imag = xi; res_ready = 1'b1;
        @(negedge clock);
        coef_valid = 1'b0;
        for (int k = 0; k < NTAPS; k++) if (idx == 32'(k)) begin ref_cr[k] = cr; ref_ci[k] = ci; end
        n_checks++;
        if (dp_valid !== 1'b1 || dp_insn !== OP_COEF || dp_rs2 !== idx || dp_rs1_real !== cr) begin
            n_errors++; $display("FAIL simul_coef_first: got v %b insn %h rs2 %0d expected 1 0b %0d", dp_valid, dp_insn, dp_rs2, idx);
        end
        @(negedge clock);
        n_checks++;
        if (dp_valid !== 1'b0 || smp_ready !== 1'b1) begin
            n_errors++; $display("FAIL simul_idle: got v %b smp_ready %b expected 0 1", dp_valid, smp_ready);
        end
        ref_xr.push_front(xr); ref_xi.push_front(xi);
        ref_expect(er, ei);
        @(negedge clock);
        smp_valid = 1'b0;
        n_checks++;
        if (dp_valid !== 1'b1 || dp_insn !== OP_PUSH || dp_rs1_real !== xr || dp_rs1_imag !== xi) begin
            n_errors++; $display("FAIL simul_push: got v %b insn %h rs1 %0d expected 1 2b %0d", dp_valid, dp_insn, dp_rs1_real, xr);
        end
        while (res_valid !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_real !== er || res_imag !== ei) begin
            n_errors++; $display("FAIL simul_result: got v %b %0d/%0d expected 1 %0d/%0d", res_valid, res_real, res_imag, er, ei);
        end
        @(negedge clock);
        res_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_errors++; $display("FAIL simul_done: got busy %b res_valid %b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset_midop();
        logic signed [63:0] xr, xi;
        int waited = 0;
        xr = rnd64(); xi = rnd64();
        smp_valid = 1'b1; smp_real = xr; smp_imag = xi; res_ready = 1'b0;
        while (smp_ready !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clock);
            waited++;
        end
        ref_xr.push_front(xr); ref_xi.push_front(xi);
        @(negedge clock);
        smp_valid = 1'b0;
        n_checks++;
        if (dp_valid !== 1'b1 || dp_insn !== OP_PUSH) begin
            n_errors++; $display("FAIL midop_push: got v %b insn %h expected 1 2b", dp_valid, dp_insn);
        end
        @(negedge clock);
        reset_n = 1'b0;
        for (int k = 0; k < NTAPS; k++) ref_seen[k] = 1'b0;
        #1;
        n_checks++;
        if (dp_valid !== 1'b0 || busy !== 1'b0 || dp_insn !== 32'h0 || res_valid !== 1'b0 || coef_ready !== 1'b1) begin
            n_errors++; $display("FAIL midop_reset: got v %b busy %b insn %h rv %b crdy %b expected 0 0 0 0 1", dp_valid, busy, dp_insn, res_valid, coef_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            n_checks++;
            if (busy !== 1'b0 || dp_valid !== 1'b0 || res_valid !== 1'b0) begin
                n_errors++; $display("FAIL midop_after: got busy %b v %b rv %b expected 0 0 0", busy, dp_valid, res_valid);
            end
        end
        for (int k = 0; k < NTAPS; k++) load_coef(32'(k), rnd64(), rnd64());
        send_sample(rnd64(), rnd64(), 2);
    endtask

    initial begin
        test_reset();
        test_coef_load();
        test_end_to_end();
        test_back_to_back();
        test_simultaneous();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
